// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
// -------------------
// Sequential read-out engine for the processor register file. A start request
// walks the inclusive address range [lo_addr, hi_addr] through one of the
// register file's asynchronous read ports. Each word is snapshotted and
// presented on a valid/ready stream together with its address and a last flag.
//
// Ports:
//   clk        - single clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - dump request, only honoured in IDLE
//   lo_addr    - first register address (sampled with start)
//   hi_addr    - last register address, inclusive (sampled with start)
//   abort      - synchronous cancel of a dump in progress
//   rf_addr    - register-file read address (0 outside READ)
//   rf_data    - register-file read data, combinational from rf_addr
//   out_valid  - output word valid
//   out_ready  - consumer accept
//   out_data   - captured register value
//   out_addr   - register address of out_data
//   out_last   - final word of the range
//   busy       - high whenever the engine is not idle
//   done       - one-cycle pulse after the last word is accepted
//   err        - one-cycle pulse when a start is rejected (lo_addr > hi_addr)
module regfile_dump_reader #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] lo_addr,
  input  logic [AW-1:0] hi_addr,
  input  logic          abort,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_addr,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [AW-1:0] MAX_ADDR = AW'(NREGS - 1);
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t        state_r, state_s;
  logic [AW-1:0] cur_r, cur_s;
  logic [AW-1:0] hi_r, hi_s;
  logic [AW-1:0] rf_addr_r, rf_addr_s;
  logic          out_valid_r, out_valid_s;
  logic [DW-1:0] out_data_r, out_data_s;
  logic [AW-1:0] out_addr_r, out_addr_s;
  logic          out_last_r, out_last_s;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic          err_r, err_s;

  // Next-state and next-output computation; every output is registered, so
  // status outputs are derived from the next state rather than the current one.
  always_comb begin
    state_s     = state_r;
    cur_s       = cur_r;
    hi_s        = hi_r;
    out_valid_s = out_valid_r;
    out_data_s  = out_data_r;
    out_addr_s  = out_addr_r;
    out_last_s  = out_last_r;
    err_s       = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if ((lo_addr <= hi_addr) && (hi_addr <= MAX_ADDR)) begin
            cur_s   = lo_addr;
            hi_s    = hi_addr;
            state_s = ST_READ;
          end else begin
            err_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ: begin
        if (abort) begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end else begin
          // Snapshot: rf_data reflects the pre-edge contents of cur.
          out_data_s  = rf_data;
          out_addr_s  = cur_r;
          out_last_s  = (cur_r == hi_r);
          out_valid_s = 1'b1;
          state_s     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_s     = ST_IDLE;
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end else if (out_ready) begin
          out_valid_s = 1'b0;
          if (out_last_r) begin
            state_s = ST_DONE;
          end else begin
            // Cannot wrap: the last word (cur == hi) takes the branch above.
            cur_s   = cur_r + ADDR_ONE;
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_HOLD;
        end
      end
      ST_DONE: begin
        if (abort) begin
          out_valid_s = 1'b0;
          out_last_s  = 1'b0;
        end else begin
          out_valid_s = out_valid_r;
        end
        state_s = ST_IDLE;
      end
      default: begin
        state_s     = ST_IDLE;
        out_valid_s = 1'b0;
        out_last_s  = 1'b0;
      end
    endcase

    busy_s    = (state_s != ST_IDLE);
    done_s    = (state_s == ST_DONE);
    rf_addr_s = (state_s == ST_READ) ? cur_s : ADDR_ZERO;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cur_r       <= ADDR_ZERO;
      hi_r        <= ADDR_ZERO;
      rf_addr_r   <= ADDR_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_ZERO;
      out_addr_r  <= ADDR_ZERO;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      cur_r       <= cur_s;
      hi_r        <= hi_s;
      rf_addr_r   <= rf_addr_s;
      out_valid_r <= out_valid_s;
      out_data_r  <= out_data_s;
      out_addr_r  <= out_addr_s;
      out_last_r  <= out_last_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign rf_addr   = rf_addr_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_addr  = out_addr_r;
  assign out_last  = out_last_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule
